// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle shared by the multi-cycle ALU and the
// pipeline control that drives it.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result2;
  logic             of;
  logic             uof;
  logic             equal;
  logic             div0;

  modport master (
    output start, op, x, y,
    input  busy, done, result, result2, of, uof, equal, div0
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, result, result2, of, uof, equal, div0
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops plus bit-serial multiply and
// restoring divide, with a start/busy/done handshake and registered outputs.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_mc_if.slave  bus
);
  localparam int unsigned CW = SHW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam logic [3:0] OpSll  = 4'd0;
  localparam logic [3:0] OpSra  = 4'd1;
  localparam logic [3:0] OpSrl  = 4'd2;
  localparam logic [3:0] OpMulu = 4'd3;
  localparam logic [3:0] OpDivu = 4'd4;
  localparam logic [3:0] OpAdd  = 4'd5;
  localparam logic [3:0] OpSub  = 4'd6;
  localparam logic [3:0] OpAnd  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpXor  = 4'd9;
  localparam logic [3:0] OpNor  = 4'd10;
  localparam logic [3:0] OpSlt  = 4'd11;
  localparam logic [3:0] OpSltu = 4'd12;
  localparam logic [3:0] OpMuls = 4'd13;
  localparam logic [3:0] OpDivs = 4'd14;
  localparam logic [3:0] OpNop  = 4'd15;

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] a_q;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q;  // product high / partial remainder
  logic [WIDTH-1:0] lo_q;  // multiplier-product low / dividend-quotient
  logic             neg_p_q, neg_r_q;
  logic [WIDTH-1:0] result_q, result2_q;
  logic             of_q, uof_q, equal_q, div0_q, done_q;

  // Single-cycle datapath, fed straight from the bus at acceptance.
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_of, sc_uof;

  always_comb begin
    sh     = bus.y[SHW-1:0];
    add_w  = {1'b0, bus.x} + {1'b0, bus.y};
    sub_w  = {1'b0, bus.x} - {1'b0, bus.y};
    sc_res = '0;
    sc_of  = of_q;
    sc_uof = uof_q;
    case (bus.op)
      OpSll:  sc_res = bus.x << sh;
      OpSra:  sc_res = $unsigned($signed(bus.x) >>> sh);
      OpSrl:  sc_res = bus.x >> sh;
      OpAdd: begin
        sc_res = add_w[WIDTH-1:0];
        sc_of  = (sc_res[WIDTH-1] ^ bus.x[WIDTH-1]) & ~(bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
        sc_uof = add_w[WIDTH];
      end
      OpSub: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_of  = (sc_res[WIDTH-1] ^ bus.x[WIDTH-1]) & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
        sc_uof = sub_w[WIDTH];
      end
      OpAnd:  sc_res = bus.x & bus.y;
      OpOr:   sc_res = bus.x | bus.y;
      OpXor:  sc_res = bus.x ^ bus.y;
      OpNor:  sc_res = ~(bus.x | bus.y);
      OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
      OpSltu: sc_res = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
      OpNop:  sc_res = '0;
      default: sc_res = '0;
    endcase
  end

  logic             iter_op, new_signed, new_mul;
  logic [WIDTH-1:0] x_mag, y_mag;

  always_comb begin
    iter_op    = (bus.op == OpMulu) || (bus.op == OpDivu) ||
                 (bus.op == OpMuls) || (bus.op == OpDivs);
    new_signed = (bus.op == OpMuls) || (bus.op == OpDivs);
    new_mul    = (bus.op == OpMulu) || (bus.op == OpMuls);
    x_mag      = (new_signed && bus.x[WIDTH-1]) ? -bus.x : bus.x;
    y_mag      = (new_signed && bus.y[WIDTH-1]) ? -bus.y : bus.y;
  end

  // One shift-add or restoring-subtract step.
  logic [WIDTH:0]   msum, rshift, rdiff;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    msum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
    rshift = {hi_q, lo_q[WIDTH-1]};
    rdiff  = rshift - {1'b0, a_q};
    if (state_q == StDiv) begin
      step_hi = rdiff[WIDTH] ? rshift[WIDTH-1:0] : rdiff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~rdiff[WIDTH]};
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Completion values; sign flags are zero for unsigned ops so the fix-up is a no-op.
  logic               last, op_signed, op_div, it_fin;
  logic [WIDTH-1:0]   fin_hi, fin_lo, it_res, it_res2;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    last      = (cnt_q == CW'(WIDTH - 1));
    op_signed = (op_q == OpMuls) || (op_q == OpDivs);
    op_div    = (op_q == OpDivu) || (op_q == OpDivs);
    fin_hi    = (state_q == StFix) ? hi_q : step_hi;
    fin_lo    = (state_q == StFix) ? lo_q : step_lo;
    prod      = {fin_hi, fin_lo};
    if (neg_p_q) prod = -prod;
    if (op_div) begin
      it_res  = neg_p_q ? -fin_lo : fin_lo;
      it_res2 = neg_r_q ? -fin_hi : fin_hi;
      if (y_q == '0) begin
        it_res  = '1;
        it_res2 = x_q;
      end
    end else begin
      it_res  = prod[WIDTH-1:0];
      it_res2 = prod[2*WIDTH-1:WIDTH];
    end
    it_fin = (state_q == StFix) ||
             (((state_q == StMul) || (state_q == StDiv)) && last && !op_signed);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_p_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      result2_q <= '0;
      of_q      <= 1'b0;
      uof_q     <= 1'b0;
      equal_q   <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q <= bus.op;
            x_q  <= bus.x;
            y_q  <= bus.y;
            if (iter_op) begin
              state_q <= new_mul ? StMul : StDiv;
              cnt_q   <= '0;
              a_q     <= y_mag;
              lo_q    <= x_mag;
              hi_q    <= '0;
              neg_p_q <= new_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
              neg_r_q <= new_signed & bus.x[WIDTH-1];
            end else begin
              result_q <= sc_res;
              of_q     <= sc_of;
              uof_q    <= sc_uof;
              equal_q  <= (bus.x == bus.y);
              div0_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CW'(1);
          if (last) state_q <= op_signed ? StFix : StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (it_fin) begin
        result_q  <= it_res;
        result2_q <= it_res2;
        equal_q   <= (x_q == y_q);
        div0_q    <= op_div && (y_q == '0);
        done_q    <= 1'b1;
      end
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.result2 = result2_q;
  assign bus.of      = of_q;
  assign bus.uof     = uof_q;
  assign bus.equal   = equal_q;
  assign bus.div0    = div0_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, abort/pulse sequences,
// and random ops compared against an arithmetic reference model.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_res, m_res2;
  logic        m_of, m_uof, m_eq, m_div0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [31:0] res2;
    bit          noise;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_res = '0; m_res2 = '0; m_of = 0; m_uof = 0; m_eq = 0; m_div0 = 0;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    longint      sx, sy, p, q, r;
    logic [63:0] u;
    logic [4:0]  s;
    sx = $signed(x);
    sy = $signed(y);
    s  = y[4:0];
    lat = 0;
    m_eq = (x == y);
    m_div0 = 0;
    case (op)
      4'd0: m_res = x << s;
      4'd1: m_res = $signed(x) >>> s;
      4'd2: m_res = x >> s;
      4'd3: begin
        u = {32'b0, x} * {32'b0, y};
        m_res = u[31:0]; m_res2 = u[63:32]; lat = W;
      end
      4'd4: begin
        lat = W;
        if (y == 0) begin m_res = '1; m_res2 = x; m_div0 = 1; end
        else begin m_res = x / y; m_res2 = x % y; end
      end
      4'd5: begin
        u = {32'b0, x} + {32'b0, y};
        m_res = u[31:0]; m_uof = u[32];
        p = sx + sy; m_of = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      4'd6: begin
        m_res = x - y; m_uof = (x < y);
        p = sx - sy; m_of = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      4'd7:  m_res = x & y;
      4'd8:  m_res = x | y;
      4'd9:  m_res = x ^ y;
      4'd10: m_res = ~(x | y);
      4'd11: m_res = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: m_res = (x < y) ? 32'd1 : 32'd0;
      4'd13: begin
        p = sx * sy;
        m_res = p[31:0]; m_res2 = p[63:32]; lat = W + 1;
      end
      4'd14: begin
        lat = W + 1;
        if (y == 0) begin m_res = '1; m_res2 = x; m_div0 = 1; end
        else begin
          q = sx / sy; r = sx % sy;
          m_res = q[31:0]; m_res2 = r[31:0];
        end
      end
      default: m_res = '0;
    endcase
  endtask

  // Issue one op (start asserted during the current cycle), wait for done, compare.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit noise);
    int          n, lat;
    bit          stable;
    logic [31:0] r0, r20;
    r0 = m_res; r20 = m_res2; stable = 1;
    @(negedge clk);
    bus.start = 1; bus.op = op; bus.x = x; bus.y = y;
    @(posedge clk); #1;
    bus.start = 0; bus.op = 4'($urandom); bus.x = $urandom; bus.y = $urandom;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1 || bus.result !== r0 || bus.result2 !== r20) stable = 0;
      bus.start = noise ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 0;
    model(op, x, y, lat);
    chk({name, " latency"}, n, lat);
    chk({name, " busy/hold during op"}, {31'b0, stable}, 32'd1);
    chk({name, " busy at done"}, {31'b0, bus.busy}, 32'd0);
    chk({name, " result"}, bus.result, m_res);
    chk({name, " result2"}, bus.result2, m_res2);
    chk({name, " of/uof/equal/div0"}, {28'b0, bus.of, bus.uof, bus.equal, bus.div0},
        {28'b0, m_of, m_uof, m_eq, m_div0});
  endtask

  initial begin
    bit saw_done;
    logic [3:0]  rop;
    logic [31:0] rx, ry;

    bus.start = 0; bus.op = '0; bus.x = '0; bus.y = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.result, 32'd0);
    chk("reset result2", bus.result2, 32'd0);
    chk("reset busy/done/of/uof/equal/div0",
        {26'b0, bus.busy, bus.done, bus.of, bus.uof, bus.equal, bus.div0}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // Directed vectors, issued back to back (each start lands on the previous done cycle).
    vecs.push_back('{"ADD ovf",     4'd5,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0,        0});
    vecs.push_back('{"SUB borrow",  4'd6,  32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        0});
    vecs.push_back('{"MULU max",    4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1});
    vecs.push_back('{"SRA b2b",     4'd1,  32'h80000000, 32'h24,       32'hF8000000, 32'hFFFFFFFE, 0});
    vecs.push_back('{"MULS -3*7",   4'd13, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1});
    vecs.push_back('{"DIVS -7/2",   4'd14, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0});
    vecs.push_back('{"DIVU 5/0",    4'd4,  32'h5,        32'h0,        32'hFFFFFFFF, 32'h5,        0});
    vecs.push_back('{"DIVS min/-1", 4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        0});
    vecs.push_back('{"OP15",        4'd15, 32'h1,        32'h1,        32'h0,        32'h0,        0});
    vecs.push_back('{"SLT",         4'd11, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        0});
    vecs.push_back('{"SLTU",        4'd12, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        0});
    vecs.push_back('{"NOR",         4'd10, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        0});
    vecs.push_back('{"DIVS 7/-2",   4'd14, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        0});
    vecs.push_back('{"SLL 31",      4'd0,  32'h1,        32'h1F,       32'h80000000, 32'h1,        0});
    vecs.push_back('{"SRL 33",      4'd2,  32'h80000000, 32'h21,       32'h40000000, 32'h1,        0});
    vecs.push_back('{"DIVS min/0",  4'd14, 32'h80000000, 32'h0,        32'hFFFFFFFF, 32'h80000000, 0});

    foreach (vecs[i]) begin
      do_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].noise);
      chk({vecs[i].name, " table result"}, bus.result, vecs[i].res);
      chk({vecs[i].name, " table result2"}, bus.result2, vecs[i].res2);
    end

    // done is a single-cycle pulse.
    @(posedge clk); #1;
    chk("done pulse width", {31'b0, bus.done}, 32'd0);

    // Reset in the middle of a DIVU aborts it without a done pulse.
    saw_done = 0;
    @(negedge clk);
    bus.start = 1; bus.op = 4'd4; bus.x = 32'h12345678; bus.y = 32'd3;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    @(negedge clk);
    rst_n = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort result", bus.result, 32'd0);
    chk("abort result2", bus.result2, 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    chk("abort no done", {31'b0, saw_done}, 32'd0);
    model_reset();
    do_op("ADD after abort", 4'd5, 32'd10, 32'd20, 0);

    // Random ops with operand mixes that reach zero/sign edges.
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom);
      rx  = $urandom;
      ry  = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = 32'($urandom_range(0, 9));
        2: rx = 32'h80000000;
        3: ry = 32'hFFFFFFFF;
        4: ry = rx;
        default: ;
      endcase
      do_op($sformatf("rand%0d op%0d", i, rop), rop, rx, ry, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
